// File: rtl/axi_reg_slice.sv
// axi_reg_slice: AXI4-full register slice. Every channel (AW, W, AR forward;
// B, R reverse) passes through an independent 2-entry skid buffer, so no
// combinational path crosses the slice and every output, READY included,
// comes straight from a flop. Sustains one beat per cycle per channel.
//
// Ports:
//   aclk, areset    clock, synchronous active-high reset
//   S_AXI_*         slave side, faces the upstream master
//   M_AXI_*         master side, drives the downstream slave
//                   (same signal set and widths as S_AXI_*, directions flipped)

// axi_reg_slice_skid: one channel's 2-entry skid buffer.
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module axi_reg_slice_skid #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    // Encoding chosen so state[0] is main_v and state[1] is skid_v.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t       state;
    logic         rdy_q;
    logic [W-1:0] main_d;
    logic [W-1:0] skid_d;
    logic         acc;
    logic         pop;

    assign acc       = in_valid & rdy_q;
    assign pop       = state[0] & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = state[0];
    assign out_data  = main_d;

    // rdy_q tracks "skid will be empty after this edge", but is held low
    // through reset so READY only rises on the first edge after release.
    // Data registers are deliberately left out of reset.
    always_ff @(posedge clk) begin
        case (state)
            EMPTY: begin
                rdy_q <= 1'b1;
                if (acc) begin
                    main_d <= in_data;
                    state  <= ONE;
                end
            end
            ONE: begin
                rdy_q <= 1'b1;
                if (acc && pop) begin
                    main_d <= in_data;
                end else if (acc) begin
                    skid_d <= in_data;
                    state  <= FULL;
                    rdy_q  <= 1'b0;
                end else if (pop) begin
                    state <= EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can happen
                rdy_q <= pop;
                if (pop) begin
                    main_d <= skid_d;
                    state  <= ONE;
                end
            end
            default: begin
                state <= EMPTY;
                rdy_q <= 1'b0;
            end
        endcase
        if (rst) begin
            state <= EMPTY;
            rdy_q <= 1'b0;
        end
    end
endmodule

module axi_reg_slice #(
    parameter int C_S_AXI_DATA_WIDTH = 64,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                            aclk,
    input  logic                            areset,
    // S side: write address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    // S side: write data
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    // S side: write response
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    // S side: read address
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                      S_AXI_ARLEN,
    input  logic [2:0]                      S_AXI_ARSIZE,
    input  logic [1:0]                      S_AXI_ARBURST,
    input  logic                            S_AXI_ARLOCK,
    input  logic [3:0]                      S_AXI_ARCACHE,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic [3:0]                      S_AXI_ARQOS,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    // S side: read data
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RLAST,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    // M side: write address
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    // M side: write data
    output logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    // M side: write response
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // M side: read address
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic [3:0]                      M_AXI_ARQOS,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    // M side: read data
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);
    localparam int AXW = C_S_AXI_ADDR_WIDTH + 25;
    localparam int WW  = C_S_AXI_DATA_WIDTH + C_S_AXI_DATA_WIDTH/8 + 1;
    localparam int BW  = 2;
    localparam int RW  = C_S_AXI_DATA_WIDTH + 3;

    logic [AXW-1:0] aw_out;
    logic [WW-1:0]  w_out;
    logic [BW-1:0]  b_out;
    logic [AXW-1:0] ar_out;
    logic [RW-1:0]  r_out;

    axi_reg_slice_skid #(.W(AXW)) u_aw (
        .clk(aclk), .rst(areset),
        .in_valid(S_AXI_AWVALID), .in_ready(S_AXI_AWREADY),
        .in_data({S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWCACHE, S_AXI_AWLOCK,
                  S_AXI_AWBURST, S_AXI_AWSIZE, S_AXI_AWLEN, S_AXI_AWADDR}),
        .out_valid(M_AXI_AWVALID), .out_ready(M_AXI_AWREADY), .out_data(aw_out)
    );
    assign {M_AXI_AWQOS, M_AXI_AWPROT, M_AXI_AWCACHE, M_AXI_AWLOCK,
            M_AXI_AWBURST, M_AXI_AWSIZE, M_AXI_AWLEN, M_AXI_AWADDR} = aw_out;

    axi_reg_slice_skid #(.W(WW)) u_w (
        .clk(aclk), .rst(areset),
        .in_valid(S_AXI_WVALID), .in_ready(S_AXI_WREADY),
        .in_data({S_AXI_WLAST, S_AXI_WSTRB, S_AXI_WDATA}),
        .out_valid(M_AXI_WVALID), .out_ready(M_AXI_WREADY), .out_data(w_out)
    );
    assign {M_AXI_WLAST, M_AXI_WSTRB, M_AXI_WDATA} = w_out;

    axi_reg_slice_skid #(.W(BW)) u_b (
        .clk(aclk), .rst(areset),
        .in_valid(M_AXI_BVALID), .in_ready(M_AXI_BREADY),
        .in_data(M_AXI_BRESP),
        .out_valid(S_AXI_BVALID), .out_ready(S_AXI_BREADY), .out_data(b_out)
    );
    assign S_AXI_BRESP = b_out;

    axi_reg_slice_skid #(.W(AXW)) u_ar (
        .clk(aclk), .rst(areset),
        .in_valid(S_AXI_ARVALID), .in_ready(S_AXI_ARREADY),
        .in_data({S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARCACHE, S_AXI_ARLOCK,
                  S_AXI_ARBURST, S_AXI_ARSIZE, S_AXI_ARLEN, S_AXI_ARADDR}),
        .out_valid(M_AXI_ARVALID), .out_ready(M_AXI_ARREADY), .out_data(ar_out)
    );
    assign {M_AXI_ARQOS, M_AXI_ARPROT, M_AXI_ARCACHE, M_AXI_ARLOCK,
            M_AXI_ARBURST, M_AXI_ARSIZE, M_AXI_ARLEN, M_AXI_ARADDR} = ar_out;

    axi_reg_slice_skid #(.W(RW)) u_r (
        .clk(aclk), .rst(areset),
        .in_valid(M_AXI_RVALID), .in_ready(M_AXI_RREADY),
        .in_data({M_AXI_RLAST, M_AXI_RRESP, M_AXI_RDATA}),
        .out_valid(S_AXI_RVALID), .out_ready(S_AXI_RREADY), .out_data(r_out)
    );
    assign {S_AXI_RLAST, S_AXI_RRESP, S_AXI_RDATA} = r_out;
endmodule

// File: tb/tb_axi_reg_slice.sv
// tb_axi_reg_slice: randomized and directed stimulus on all five channels,
// checked each cycle against a per-channel 2-deep FIFO reference model.
// Channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R.
module tb_axi_reg_slice;
    localparam int DW = 64;
    localparam int AW = 7;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    logic [4:0]   in_v;
    logic [4:0]   out_r;
    wire  [4:0]   in_rdy;
    wire  [4:0]   out_vld;
    logic [127:0] in_d [5];
    wire  [127:0] out_d [5];

    int WID [5] = '{AW+25, DW+DW/8+1, AW+25, 2, DW+3};

    // DUT outputs that carry payload
    wire [AW-1:0] m_awaddr, m_araddr;
    wire [7:0]    m_awlen, m_arlen;
    wire [2:0]    m_awsize, m_arsize, m_awprot, m_arprot;
    wire [1:0]    m_awburst, m_arburst, s_bresp, s_rresp;
    wire          m_awlock, m_arlock, m_wlast, s_rlast;
    wire [3:0]    m_awcache, m_arcache, m_awqos, m_arqos;
    wire [DW-1:0] m_wdata, s_rdata;
    wire [DW/8-1:0] m_wstrb;

    assign out_d[0] = {96'b0, m_awqos, m_awprot, m_awcache, m_awlock, m_awburst, m_awsize, m_awlen, m_awaddr};
    assign out_d[1] = {55'b0, m_wlast, m_wstrb, m_wdata};
    assign out_d[2] = {96'b0, m_arqos, m_arprot, m_arcache, m_arlock, m_arburst, m_arsize, m_arlen, m_araddr};
    assign out_d[3] = {126'b0, s_bresp};
    assign out_d[4] = {61'b0, s_rlast, s_rresp, s_rdata};

    axi_reg_slice #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .areset(areset),
        .S_AXI_AWADDR(in_d[0][6:0]), .S_AXI_AWLEN(in_d[0][14:7]), .S_AXI_AWSIZE(in_d[0][17:15]),
        .S_AXI_AWBURST(in_d[0][19:18]), .S_AXI_AWLOCK(in_d[0][20]), .S_AXI_AWCACHE(in_d[0][24:21]),
        .S_AXI_AWPROT(in_d[0][27:25]), .S_AXI_AWQOS(in_d[0][31:28]),
        .S_AXI_AWVALID(in_v[0]), .S_AXI_AWREADY(in_rdy[0]),
        .S_AXI_WDATA(in_d[1][63:0]), .S_AXI_WSTRB(in_d[1][71:64]), .S_AXI_WLAST(in_d[1][72]),
        .S_AXI_WVALID(in_v[1]), .S_AXI_WREADY(in_rdy[1]),
        .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(out_vld[3]), .S_AXI_BREADY(out_r[3]),
        .S_AXI_ARADDR(in_d[2][6:0]), .S_AXI_ARLEN(in_d[2][14:7]), .S_AXI_ARSIZE(in_d[2][17:15]),
        .S_AXI_ARBURST(in_d[2][19:18]), .S_AXI_ARLOCK(in_d[2][20]), .S_AXI_ARCACHE(in_d[2][24:21]),
        .S_AXI_ARPROT(in_d[2][27:25]), .S_AXI_ARQOS(in_d[2][31:28]),
        .S_AXI_ARVALID(in_v[2]), .S_AXI_ARREADY(in_rdy[2]),
        .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp), .S_AXI_RLAST(s_rlast),
        .S_AXI_RVALID(out_vld[4]), .S_AXI_RREADY(out_r[4]),
        .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWSIZE(m_awsize),
        .M_AXI_AWBURST(m_awburst), .M_AXI_AWLOCK(m_awlock), .M_AXI_AWCACHE(m_awcache),
        .M_AXI_AWPROT(m_awprot), .M_AXI_AWQOS(m_awqos),
        .M_AXI_AWVALID(out_vld[0]), .M_AXI_AWREADY(out_r[0]),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WLAST(m_wlast),
        .M_AXI_WVALID(out_vld[1]), .M_AXI_WREADY(out_r[1]),
        .M_AXI_BRESP(in_d[3][1:0]), .M_AXI_BVALID(in_v[3]), .M_AXI_BREADY(in_rdy[3]),
        .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen), .M_AXI_ARSIZE(m_arsize),
        .M_AXI_ARBURST(m_arburst), .M_AXI_ARLOCK(m_arlock), .M_AXI_ARCACHE(m_arcache),
        .M_AXI_ARPROT(m_arprot), .M_AXI_ARQOS(m_arqos),
        .M_AXI_ARVALID(out_vld[2]), .M_AXI_ARREADY(out_r[2]),
        .M_AXI_RDATA(in_d[4][63:0]), .M_AXI_RRESP(in_d[4][65:64]), .M_AXI_RLAST(in_d[4][66]),
        .M_AXI_RVALID(in_v[4]), .M_AXI_RREADY(in_rdy[4])
    );

    // Reference model: each channel is a FIFO of depth 2; ready means "room",
    // but only from the first edge after reset release.
    logic [127:0] mem [5][2];
    int           cnt [5];
    bit           rdy_en;
    bit           acc_l [5];
    int           n_chk = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input int c, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s ch%0d: got %h expected %h", tag, c, got, exp);
        end
    endtask

    function automatic logic [127:0] msk(input int c);
        return (128'(1) << WID[c]) - 128'(1);
    endfunction

    function automatic logic [127:0] rnd(input int c);
        return {$urandom, $urandom, $urandom, $urandom} & msk(c);
    endfunction

    // Called at a negedge after inputs for the coming edge are set:
    // checks outputs against the model, then advances the model over that edge.
    task automatic step();
        for (int c = 0; c < 5; c++) begin
            chk("valid", c, 128'(out_vld[c]), 128'(cnt[c] != 0));
            chk("ready", c, 128'(in_rdy[c]), 128'(rdy_en && cnt[c] < 2));
            if (cnt[c] != 0) chk("data", c, out_d[c], mem[c][0]);
        end
        for (int c = 0; c < 5; c++) begin
            bit acc, pop;
            acc = in_v[c] && rdy_en && cnt[c] < 2 && !areset;
            pop = out_r[c] && cnt[c] != 0 && !areset;
            acc_l[c] = acc;
            if (areset) cnt[c] = 0;
            if (pop) begin
                mem[c][0] = mem[c][1];
                cnt[c]--;
            end
            if (acc) begin
                mem[c][cnt[c]] = in_d[c] & msk(c);
                cnt[c]++;
            end
        end
        rdy_en = !areset;
        @(posedge aclk);
        @(negedge aclk);
    endtask

    // Offer one beat on channel c and hold it until the model accepts it.
    task automatic send(input int c, input logic [127:0] d);
        in_d[c] = d;
        in_v[c] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_l[c]) break;
        end
        chk("send_acc", c, 128'(acc_l[c]), 128'(1));
        in_v[c] = 1'b0;
    endtask

    initial begin
        logic [127:0] d;
        areset = 1'b1;
        in_v   = 5'b11111;
        out_r  = 5'b11111;
        for (int c = 0; c < 5; c++) begin
            in_d[c] = rnd(c);
            cnt[c]  = 0;
            acc_l[c] = 1'b0;
        end
        rdy_en = 1'b0;
        @(posedge aclk);
        @(negedge aclk);

        // reset held 3 cycles, then release: READY rises one edge later
        repeat (3) step();
        areset = 1'b0;
        step();
        in_v = '0;
        step();

        // streaming write: AW addr 0x10 len 3, then 4 W beats
        d = '0; d[6:0] = 7'h10; d[14:7] = 8'd3;
        send(0, d);
        for (int i = 1; i <= 4; i++) begin
            d = 128'(i); d[71:64] = 8'hFF; d[72] = (i == 4);
            send(1, d);
            chk("w_stream", 1, 128'(in_rdy[1]), 128'(1));
        end
        repeat (2) step();

        // AR backpressure: 3 beats offered while downstream stalls
        out_r[2] = 1'b0;
        in_v[2]  = 1'b1;
        in_d[2] = 128'h20; step();
        in_d[2] = 128'h24; step();
        in_d[2] = 128'h28; step(); step();
        chk("arready_low", 2, 128'(in_rdy[2]), 128'(0));
        chk("araddr_hold", 2, 128'(m_araddr), 128'h20);
        out_r[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc_l[2]) break;
        end
        in_v[2] = 1'b0;
        repeat (3) step();

        // R beats with upstream RREADY stalling in between
        in_v[4] = 1'b1;
        in_d[4] = 128'hAA; step();
        d = 128'hBB; d[66] = 1'b1; in_d[4] = d; step();
        in_v[4] = 1'b0; out_r[4] = 1'b0; step();
        chk("rdata_stall", 4, 128'(s_rdata), 128'hBB);
        step();
        out_r[4] = 1'b1; step(); step();
        // B response SLVERR
        send(3, 128'h2);
        chk("bresp", 3, 128'(s_bresp), 128'h2);
        step();

        // acc & pop together in ONE: one beat per cycle sustained
        out_r = 5'b11111;
        in_v[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_d[1] = rnd(1);
            step();
            chk("w_rate", 1, 128'(acc_l[1]), 128'(1));
        end
        in_v[1] = 1'b0;
        step();

        // reset while W is FULL: held beats are discarded
        out_r[1] = 1'b0;
        send(1, rnd(1));
        send(1, rnd(1));
        step();
        chk("w_full", 1, 128'(in_rdy[1]), 128'(0));
        areset = 1'b1; step();
        chk("w_rst_vld", 1, 128'(out_vld[1]), 128'(0));
        areset = 1'b0; step();
        out_r[1] = 1'b1;
        repeat (3) step();

        // constrained random on all channels; payload held until accepted
        for (int n = 0; n < 10000; n++) begin
            for (int c = 0; c < 5; c++) begin
                if (!in_v[c] || acc_l[c]) begin
                    in_v[c] = ($urandom_range(0, 3) != 0);
                    in_d[c] = rnd(c);
                end
            end
            out_r = 5'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/axi_reg_slice.md
Name: axi_reg_slice

Overview:
- AXI4-full register slice that breaks all combinational paths between an upstream master and a downstream slave.
- Inserted directly ahead of the AXI passthrough stage in block designs. Its M-side feeds the passthrough S-side.
- Each of the five channels (AW, W, AR forward; B, R reverse) gets an independent 2-entry skid buffer.
- Full throughput (one beat per cycle per channel); every output, including ready, is driven from a flop.

Parameters:
- C_S_AXI_DATA_WIDTH, 64, data bus width in bits; multiple of 8, range 32..1024.
- C_S_AXI_ADDR_WIDTH, 7, address width in bits; range 1..64.

Ports:
- aclk  in  1  sole clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- S_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS  in  ADDR_W/8/3/2/1/4/3/4  slave write-address payload.
- S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  AW handshake.
- S_AXI_WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1; S_AXI_WVALID in 1, S_AXI_WREADY out 1.
- S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
- S_AXI_ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS  in  same widths as AW; S_AXI_ARVALID in 1, S_AXI_ARREADY out 1.
- S_AXI_RDATA/RRESP/RLAST  out  DATA_W/2/1; S_AXI_RVALID out 1, S_AXI_RREADY in 1.
- M_AXI_*  mirror of every S_AXI_* signal with direction reversed, identical widths; drives the downstream slave.

Behaviour:
- Channel packing:
  - AW and AR payload: ADDR_W+25 bits.
  - W: DATA_W+DATA_W/8+1.
  - B: 2.
  - R: DATA_W+3.
- All five channels share one skid-buffer behaviour, specified once below with generic in_valid/in_ready/in_data and out_valid/out_ready/out_data.
- Per-channel state: main register (main_v, main_d), skid register (skid_v, skid_d). in_ready is the flop value ~skid_v; out_valid = main_v; out_data = main_d.
- States:
  - EMPTY (main_v=0, skid_v=0).
  - ONE (main_v=1, skid_v=0).
  - FULL (main_v=1, skid_v=1).
- Transitions each cycle, with acc = in_valid & in_ready and pop = out_valid & out_ready:
  - EMPTY, acc: load main, go to ONE.
  - ONE, acc & ~pop: load skid, go to FULL.
  - ONE, acc & pop: load main with new beat, stay in ONE.
  - ONE, ~acc & pop: go to EMPTY.
  - FULL, pop: move skid to main, go to ONE. No acc is possible because in_ready=0.
  - FULL, ~pop: hold; both registers stable.
- Latency: an accepted beat appears on the output the next cycle. Minimum 1 cycle, no bubble under continuous valid/ready.
- Ordering: strict FIFO per channel. No cross-channel coupling; a W beat may pass an AW beat, as AXI allows.
- out_valid never drops without pop. out_data is stable while out_valid & ~out_ready.
- Reset (areset=1 at a clock edge):
  - All main_v and skid_v clear to 0, so every *VALID output is 0.
  - Every *READY output (S_AXI_AWREADY/WREADY/ARREADY, M_AXI_BREADY/RREADY) is 0 while areset is high and becomes 1 on the first edge after areset deasserts.
  - Data registers are not reset; their contents are don't-care while valid is 0.
- Reset mid-burst: beats held in the slice are discarded. Recovery of the system is the responsibility of the upstream and downstream resets.
- No payload field is modified or interpreted; WLAST and RLAST are carried as data.

Test Plan:
- Reset release: hold areset for 3 cycles, then drop it -> all *VALID=0 throughout; the *READY outputs read 0 during reset and 1 one cycle after release.
- Streaming write: AW addr=0x10, len=3 followed by 4 W beats 0x1..0x4 with WLAST on beat 4, M_AXI_WREADY=1 throughout -> M side shows the same values one cycle later, back-to-back, WLAST on beat 4, S_AXI_WREADY never 0.
- Backpressure: M_AXI_ARREADY=0 while 3 AR beats (0x20, 0x24, 0x28) are offered -> S_AXI_ARREADY drops after 2 beats are accepted, M_AXI_ARADDR holds 0x20; on release the M side emits 0x20, 0x24, 0x28 in order with none lost or duplicated.
- Reverse channels: downstream returns R beats 0xAA/OKAY and 0xBB/OKAY with RLAST on the second, S_AXI_RREADY toggling 1,0,1 -> S side shows 0xAA then 0xBB, with RDATA stable during the stall. Likewise BRESP=2'b10 propagates with 1-cycle latency.
- Simultaneous acc & pop in ONE: alternating beats with both sides ready -> state stays ONE and 1 beat/cycle is sustained.
- Reset mid-operation: assert areset while the W channel is FULL -> M_AXI_WVALID=0 the next cycle and no stale beat appears after release.
- Random: constrained-random valid/ready on all 5 channels for 10k cycles with a scoreboard -> in-order, lossless delivery and AXI stability checks pass.
